// File: rtl/multicycle_control.sv
// Multicycle RISC-V controller: Moore FSM sequencing one instruction phase per cycle
// and driving every datapath enable and mux select.
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] f3,
  input  logic [6:0] f7,
  input  logic       zero,
  output logic       pcWrite,
  output logic       adrSrc,
  output logic       memWrite,
  output logic       irWrite,
  output logic [1:0] resultSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] immSrc,
  output logic       regWrite,
  output logic [2:0] aluControl,
  output logic       instrDone,
  output logic       illegal
);

  localparam int unsigned OpW = 7;

  localparam logic [OpW-1:0] OpLw   = 7'b0000011;
  localparam logic [OpW-1:0] OpSw   = 7'b0100011;
  localparam logic [OpW-1:0] OpR    = 7'b0110011;
  localparam logic [OpW-1:0] OpI    = 7'b0010011;
  localparam logic [OpW-1:0] OpBeq  = 7'b1100011;
  localparam logic [OpW-1:0] OpJal  = 7'b1101111;

  typedef enum logic [3:0] {
    Fetch,
    Decode,
    MemAdr,
    MemRead,
    MemWb,
    MemWrite,
    ExecuteR,
    ExecuteI,
    AluWb,
    Beq,
    Jal,
    Error
  } stateT;

  stateT       state;
  stateT       nextState;
  logic        pcUpdate;
  logic        branch;
  logic [1:0]  aluOp;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= Fetch;
    end else begin
      state <= nextState;
    end
  end

  // Next state and Moore outputs
  always_comb begin
    nextState  = state;
    pcUpdate   = 1'b0;
    branch     = 1'b0;
    aluOp      = 2'b00;
    pcWrite    = 1'b0;
    adrSrc     = 1'b0;
    memWrite   = 1'b0;
    irWrite    = 1'b0;
    resultSrc  = 2'b00;
    aluSrcA    = 2'b00;
    aluSrcB    = 2'b00;
    immSrc     = 2'b00;
    regWrite   = 1'b0;
    aluControl = 3'b000;
    instrDone  = 1'b0;
    illegal    = 1'b0;

    unique case (state)
      Fetch: begin
        irWrite   = 1'b1;
        aluSrcB   = 2'b10;
        resultSrc = 2'b10;
        pcUpdate  = 1'b1;
        nextState = Decode;
      end
      Decode: begin
        // Branch target is computed here so BEQ and JAL can use ALUOut
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
        unique case (op)
          OpLw, OpSw: nextState = MemAdr;
          OpR:        nextState = ExecuteR;
          OpI:        nextState = ExecuteI;
          OpBeq:      nextState = Beq;
          OpJal:      nextState = Jal;
          default:    nextState = Error;
        endcase
      end
      MemAdr: begin
        aluSrcA   = 2'b10;
        aluSrcB   = 2'b01;
        nextState = (op == OpLw) ? MemRead : MemWrite;
      end
      MemRead: begin
        adrSrc    = 1'b1;
        nextState = MemWb;
      end
      MemWb: begin
        resultSrc = 2'b01;
        regWrite  = 1'b1;
        instrDone = 1'b1;
        nextState = Fetch;
      end
      MemWrite: begin
        adrSrc    = 1'b1;
        memWrite  = 1'b1;
        instrDone = 1'b1;
        nextState = Fetch;
      end
      ExecuteR: begin
        aluSrcA   = 2'b10;
        aluOp     = 2'b10;
        nextState = AluWb;
      end
      ExecuteI: begin
        aluSrcA   = 2'b10;
        aluSrcB   = 2'b01;
        aluOp     = 2'b10;
        nextState = AluWb;
      end
      AluWb: begin
        regWrite  = 1'b1;
        instrDone = 1'b1;
        nextState = Fetch;
      end
      Beq: begin
        aluSrcA   = 2'b10;
        aluOp     = 2'b01;
        branch    = 1'b1;
        instrDone = 1'b1;
        nextState = Fetch;
      end
      Jal: begin
        // PC takes the target from ALUOut while the ALU forms oldPC + 4 for rd
        aluSrcA   = 2'b01;
        aluSrcB   = 2'b10;
        pcUpdate  = 1'b1;
        nextState = AluWb;
      end
      Error: begin
        illegal   = 1'b1;
        nextState = Error;
      end
      default: nextState = Error;
    endcase

    unique case (aluOp)
      2'b01: aluControl = 3'b001;
      2'b10: begin
        unique case (f3)
          3'b000:  aluControl = (op[5] & f7[5]) ? 3'b001 : 3'b000;
          3'b010:  aluControl = 3'b101;
          3'b110:  aluControl = 3'b011;
          3'b111:  aluControl = 3'b010;
          default: aluControl = 3'b000;
        endcase
      end
      default: aluControl = 3'b000;
    endcase

    unique case (op)
      OpSw:    immSrc = 2'b01;
      OpBeq:   immSrc = 2'b10;
      OpJal:   immSrc = 2'b11;
      default: immSrc = 2'b00;
    endcase

    pcWrite = pcUpdate | (branch & zero);

    // Reset cycle: nothing may be enabled, whatever the stale state says
    if (rst) begin
      pcWrite    = 1'b0;
      adrSrc     = 1'b0;
      memWrite   = 1'b0;
      irWrite    = 1'b0;
      resultSrc  = 2'b00;
      aluSrcA    = 2'b00;
      aluSrcB    = 2'b00;
      immSrc     = 2'b00;
      regWrite   = 1'b0;
      aluControl = 3'b000;
      instrDone  = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: expected per-cycle output sequences built from the
// instruction's phase list, plus table vectors and reset/illegal corner cases.
module tb_multicycle_control;

  localparam logic [6:0] LW = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011;
  localparam logic [6:0] RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011;
  localparam logic [6:0] BQ = 7'b1100011;
  localparam logic [6:0] JL = 7'b1101111;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       zero;
  logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, instrDone, illegal;
  logic [1:0] resultSrc, aluSrcA, aluSrcB, immSrc;
  logic [2:0] aluControl;
  logic [17:0] outs;

  int checks = 0;
  int errors = 0;
  logic [17:0] expQ[$];

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst(rst), .op(op), .f3(f3), .f7(f7), .zero(zero),
    .pcWrite(pcWrite), .adrSrc(adrSrc), .memWrite(memWrite), .irWrite(irWrite),
    .resultSrc(resultSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .immSrc(immSrc),
    .regWrite(regWrite), .aluControl(aluControl), .instrDone(instrDone), .illegal(illegal)
  );

  assign outs = {pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB,
                 immSrc, regWrite, aluControl, instrDone, illegal};

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [2:0] expAlu;
    int         expLen;
  } vecT;

  function automatic logic [1:0] immFor(input logic [6:0] o);
    if (o == SW) return 2'b01;
    if (o == BQ) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] functAlu(input logic [6:0] o, input logic [2:0] fn3,
                                          input logic [6:0] fn7);
    case (fn3)
      3'd0:    return (o[5] && fn7[5]) ? 3'd1 : 3'd0;
      3'd2:    return 3'd5;
      3'd6:    return 3'd3;
      3'd7:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [17:0] mk(input bit pcW, input bit adr, input bit memW,
                                     input bit irW, input logic [1:0] res,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input bit regW, input logic [2:0] aluC,
                                     input bit done, input bit ill, input logic [1:0] imm);
    return {pcW, adr, memW, irW, res, a, b, imm, regW, aluC, done, ill};
  endfunction

  // Expected outputs, one entry per cycle, from FETCH to the last phase
  task automatic buildSeq(input logic [6:0] o, input logic [2:0] fn3, input logic [6:0] fn7,
                          input bit zeroBeq, input int errCycles);
    logic [1:0]  imm;
    logic [17:0] aluWb;
    logic [17:0] memAdr;
    imm    = immFor(o);
    aluWb  = mk(0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 1, 3'd0, 1, 0, imm);
    memAdr = mk(0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 0, 3'd0, 0, 0, imm);
    expQ.delete();
    expQ.push_back(mk(1, 0, 0, 1, 2'd2, 2'd0, 2'd2, 0, 3'd0, 0, 0, imm));
    expQ.push_back(mk(0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 0, 3'd0, 0, 0, imm));
    if (o == LW) begin
      expQ.push_back(memAdr);
      expQ.push_back(mk(0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 0, 3'd0, 0, 0, imm));
      expQ.push_back(mk(0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 1, 3'd0, 1, 0, imm));
    end else if (o == SW) begin
      expQ.push_back(memAdr);
      expQ.push_back(mk(0, 1, 1, 0, 2'd0, 2'd0, 2'd0, 0, 3'd0, 1, 0, imm));
    end else if (o == RT) begin
      expQ.push_back(mk(0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 0, functAlu(o, fn3, fn7), 0, 0, imm));
      expQ.push_back(aluWb);
    end else if (o == IT) begin
      expQ.push_back(mk(0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 0, functAlu(o, fn3, fn7), 0, 0, imm));
      expQ.push_back(aluWb);
    end else if (o == BQ) begin
      expQ.push_back(mk(zeroBeq, 0, 0, 0, 2'd0, 2'd2, 2'd0, 0, 3'd1, 1, 0, imm));
    end else if (o == JL) begin
      expQ.push_back(mk(1, 0, 0, 0, 2'd0, 2'd1, 2'd2, 0, 3'd0, 0, 0, imm));
      expQ.push_back(aluWb);
    end else begin
      for (int i = 0; i < errCycles; i++)
        expQ.push_back(mk(0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 3'd0, 0, 1, imm));
    end
  endtask

  task automatic check(input string name, input logic [17:0] got, input logic [17:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Drive one instruction through its whole sequence; zeroMode < 0 picks zero at random
  task automatic runInstr(input logic [6:0] o, input logic [2:0] fn3, input logic [6:0] fn7,
                          input int zeroMode, input int errCycles, input int stopAt);
    bit zeroBeq;
    zeroBeq = (zeroMode < 0) ? 1'($urandom) : (zeroMode != 0);
    buildSeq(o, fn3, fn7, zeroBeq, errCycles);
    for (int k = 0; k < expQ.size() && k < stopAt; k++) begin
      op   = o;
      f3   = fn3;
      f7   = fn7;
      zero = (k == 2 && o == BQ) ? zeroBeq : 1'($urandom);
      @(negedge clk);
      check($sformatf("op%b f3%0d cyc%0d", o, fn3, k), outs, expQ[k]);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset(input string name);
    rst = 1'b1;
    @(negedge clk);
    check(name, outs, 18'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  vecT vecs[12];

  initial begin
    vecT   v;
    int    len;
    bit    done;
    logic [6:0] rop;
    logic [6:0] illOps[4];
    logic [6:0] legalOps[6];

    rst  = 1'b1;
    op   = 7'd0;
    f3   = 3'd0;
    f7   = 7'd0;
    zero = 1'b0;
    @(posedge clk);
    #1;
    doReset("reset");

    // Table vectors: aluControl in the third cycle and instruction length
    vecs[0]  = '{RT, 3'd0, 7'h00, 3'd0, 4};
    vecs[1]  = '{RT, 3'd0, 7'h20, 3'd1, 4};
    vecs[2]  = '{IT, 3'd0, 7'h20, 3'd0, 4};
    vecs[3]  = '{RT, 3'd2, 7'h00, 3'd5, 4};
    vecs[4]  = '{RT, 3'd6, 7'h00, 3'd3, 4};
    vecs[5]  = '{IT, 3'd7, 7'h00, 3'd2, 4};
    vecs[6]  = '{IT, 3'd1, 7'h00, 3'd0, 4};
    vecs[7]  = '{RT, 3'd4, 7'h20, 3'd0, 4};
    vecs[8]  = '{LW, 3'd2, 7'h00, 3'd0, 5};
    vecs[9]  = '{SW, 3'd2, 7'h00, 3'd0, 4};
    vecs[10] = '{BQ, 3'd0, 7'h00, 3'd1, 3};
    vecs[11] = '{JL, 3'd0, 7'h00, 3'd0, 4};
    for (int i = 0; i < 12; i++) begin
      v    = vecs[i];
      op   = v.op;
      f3   = v.f3;
      f7   = v.f7;
      zero = 1'b0;
      len  = 0;
      done = 1'b0;
      for (int c = 0; c < 8 && !done; c++) begin
        @(negedge clk);
        if (c == 2) begin
          checks++;
          if (aluControl !== v.expAlu) begin
            errors++;
            $display("FAIL vec%0d aluControl got %b expected %b", i, aluControl, v.expAlu);
          end
        end
        if (instrDone === 1'b1) begin
          done = 1'b1;
          len  = c + 1;
        end
        @(posedge clk);
        #1;
      end
      checks++;
      if (len != v.expLen) begin
        errors++;
        $display("FAIL vec%0d length got %0d expected %0d", i, len, v.expLen);
      end
    end

    // Branch taken and not taken, store, load
    runInstr(BQ, 3'd0, 7'd0, 1, 0, 99);
    runInstr(BQ, 3'd0, 7'd0, 0, 0, 99);
    runInstr(SW, 3'd2, 7'd0, -1, 0, 99);
    runInstr(LW, 3'd2, 7'd0, -1, 0, 99);

    // Illegal opcode parks in ERROR until reset
    runInstr(7'b1111111, 3'd0, 7'd0, -1, 10, 99);
    doReset("resetFromError");
    runInstr(RT, 3'd0, 7'h20, -1, 0, 99);

    // Reset during MEMREAD aborts the load
    runInstr(LW, 3'd2, 7'd0, -1, 0, 3);
    rst = 1'b1;
    @(negedge clk);
    check("rstInMemRead", outs, 18'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rstHeld", outs, 18'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    runInstr(LW, 3'd2, 7'd0, -1, 0, 99);

    // Random instruction stream
    illOps   = '{7'b0000000, 7'b1111111, 7'b0110111, 7'b1100111};
    legalOps = '{LW, SW, RT, IT, BQ, JL};
    for (int n = 0; n < 60; n++) begin
      int idx;
      idx = int'($urandom % 7);
      rop = (idx == 6) ? illOps[int'($urandom % 4)] : legalOps[idx];
      runInstr(rop, 3'($urandom), 7'($urandom), -1, 1 + int'($urandom % 4), 99);
      if (idx == 6) doReset("resetRandom");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
